// File: rtl/regfile_sb_if.sv
// Operand read, issue, write-back and scoreboard status bundle for regfile_sb.
// master = pipeline (decode/issue/write-back), slave = register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_use;
  logic            rs2_use;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            iss_valid;
  logic            iss_rd_we;
  logic [AW-1:0]   iss_rd;
  logic            stall;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic [AW:0]     busy_cnt;

  modport master (
    output rs1_addr, rs2_addr, rs1_use, rs2_use,
    output iss_valid, iss_rd_we, iss_rd,
    output wb_we, wb_addr, wb_data, flush,
    input  rs1_data, rs2_data, stall, busy_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, rs1_use, rs2_use,
    input  iss_valid, iss_rd_we, iss_rd,
    input  wb_we, wb_addr, wb_data, flush,
    output rs1_data, rs2_data, stall, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and per-register busy scoreboard.
// Decode reads two operands combinationally; issue sets busy, write-back clears it.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave rf
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     cnt_nxt;

  logic rs1_fwd, rs2_fwd, rd_fwd;
  logic rs1_busy_eff, rs2_busy_eff, rd_busy_eff;
  logic stall;
  logic issue_set;

  function automatic logic is_x0(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A same-cycle write-back to a busy register both forwards its data and
  // hides the busy bit, so the consumer can issue without a bubble.
  always_comb begin
    rs1_fwd      = (BYPASS != 0) && rf.wb_we && (rf.wb_addr == rf.rs1_addr);
    rs2_fwd      = (BYPASS != 0) && rf.wb_we && (rf.wb_addr == rf.rs2_addr);
    rd_fwd       = (BYPASS != 0) && rf.wb_we && (rf.wb_addr == rf.iss_rd);
    rs1_busy_eff = busy[rf.rs1_addr] && !rs1_fwd && !is_x0(rf.rs1_addr);
    rs2_busy_eff = busy[rf.rs2_addr] && !rs2_fwd && !is_x0(rf.rs2_addr);
    rd_busy_eff  = busy[rf.iss_rd]   && !rd_fwd  && !is_x0(rf.iss_rd);
    stall        = rf.iss_valid && !rf.flush &&
                   ((rf.rs1_use   && rs1_busy_eff) ||
                    (rf.rs2_use   && rs2_busy_eff) ||
                    (rf.iss_rd_we && rd_busy_eff));
    issue_set    = rf.iss_valid && !stall && rf.iss_rd_we && !is_x0(rf.iss_rd);
  end

  assign rf.stall    = stall;
  assign rf.rs1_data = is_x0(rf.rs1_addr) ? '0 :
                       rs1_fwd            ? rf.wb_data : regs[rf.rs1_addr];
  assign rf.rs2_data = is_x0(rf.rs2_addr) ? '0 :
                       rs2_fwd            ? rf.wb_data : regs[rf.rs2_addr];
  assign rf.busy_cnt = busy_cnt_q;

  // Set is applied after clear so a new producer keeps ownership of rd.
  always_comb begin
    busy_nxt = busy;
    if (rf.flush) begin
      busy_nxt = '0;
    end else begin
      if (rf.wb_we)
        busy_nxt[rf.wb_addr] = 1'b0;
      if (issue_set)
        busy_nxt[rf.iss_rd] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (rf.wb_we && !is_x0(rf.wb_addr)) begin
      regs[rf.wb_addr] <= rf.wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Two builds side by side: dut0 (BYPASS=1, ZERO_REG=1) and dut1 (BYPASS=0, ZERO_REG=0),
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]   rs1_addr, rs2_addr, iss_rd, wb_addr;
  logic            rs1_use, rs2_use, iss_valid, iss_rd_we, wb_we, flush;
  logic [XLEN-1:0] wb_data;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) if0 ();
  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) if1 ();

  assign if0.rs1_addr  = rs1_addr;   assign if1.rs1_addr  = rs1_addr;
  assign if0.rs2_addr  = rs2_addr;   assign if1.rs2_addr  = rs2_addr;
  assign if0.rs1_use   = rs1_use;    assign if1.rs1_use   = rs1_use;
  assign if0.rs2_use   = rs2_use;    assign if1.rs2_use   = rs2_use;
  assign if0.iss_valid = iss_valid;  assign if1.iss_valid = iss_valid;
  assign if0.iss_rd_we = iss_rd_we;  assign if1.iss_rd_we = iss_rd_we;
  assign if0.iss_rd    = iss_rd;     assign if1.iss_rd    = iss_rd;
  assign if0.wb_we     = wb_we;      assign if1.wb_we     = wb_we;
  assign if0.wb_addr   = wb_addr;    assign if1.wb_addr   = wb_addr;
  assign if0.wb_data   = wb_data;    assign if1.wb_data   = wb_data;
  assign if0.flush     = flush;      assign if1.flush     = flush;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1), .ZERO_REG(1))
    dut0 (.clk(clk), .rst(rst), .rf(if0.slave));
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0), .ZERO_REG(0))
    dut1 (.clk(clk), .rst(rst), .rf(if1.slave));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state: architectural value and "awaiting write-back" flag per register.
  logic [XLEN-1:0] m_reg  [2][NREG];
  bit              m_busy [2][NREG];

  function automatic bit bp(input int k); return k == 0; endfunction
  function automatic bit zr(input int k); return k == 0; endfunction

  function automatic logic [XLEN-1:0] m_read(input int k, input logic [AW-1:0] a);
    if (zr(k) && a == 0) return '0;
    if (bp(k) && wb_we && wb_addr == a) return wb_data;
    return m_reg[k][a];
  endfunction

  function automatic bit m_pending(input int k, input logic [AW-1:0] a);
    if (zr(k) && a == 0) return 1'b0;
    return m_busy[k][a] && !(bp(k) && wb_we && wb_addr == a);
  endfunction

  function automatic bit m_stall(input int k);
    if (!iss_valid || flush) return 1'b0;
    return (rs1_use && m_pending(k, rs1_addr)) || (rs2_use && m_pending(k, rs2_addr)) ||
           (iss_rd_we && m_pending(k, iss_rd));
  endfunction

  function automatic int m_count(input int k);
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_busy[k][r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREG; r++) begin
        m_reg[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit issued;
      issued = iss_valid && !m_stall(k) && iss_rd_we && !(zr(k) && iss_rd == 0);
      if (wb_we && !(zr(k) && wb_addr == 0)) m_reg[k][wb_addr] = wb_data;
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_busy[k][r] = 1'b0;
      end else begin
        if (wb_we) m_busy[k][wb_addr] = 1'b0;
        if (issued) m_busy[k][iss_rd] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) if (!rst) model_step();

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                     input logic st, input logic [AW:0] cnt);
    chk($sformatf("dut%0d rs1_data", k), r1, m_read(k, rs1_addr));
    chk($sformatf("dut%0d rs2_data", k), r2, m_read(k, rs2_addr));
    chk($sformatf("dut%0d stall", k), 32'(st), 32'(m_stall(k)));
    chk($sformatf("dut%0d busy_cnt", k), 32'(cnt), 32'(m_count(k)));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, if0.rs1_data, if0.rs2_data, if0.stall, if0.busy_cnt);
      cmp(1, if1.rs1_data, if1.rs2_data, if1.stall, if1.busy_cnt);
    end
  end

  task automatic idle();
    rs1_addr = '0; rs2_addr = '0; rs1_use = 1'b0; rs2_use = 1'b0;
    iss_valid = 1'b0; iss_rd_we = 1'b0; iss_rd = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic issue_rd(input logic [AW-1:0] rd);
    next_cycle();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = rd;
  endtask

  task automatic write_back(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    next_cycle();
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("reset busy_cnt0", 32'(if0.busy_cnt), 32'd0);
    chk("reset busy_cnt1", 32'(if1.busy_cnt), 32'd0);
    chk("reset stall0", 32'(if0.stall), 32'd0);

    // Register 0: hardwired on dut0, ordinary on dut1.
    write_back(0, 32'hDEADBEEF);
    @(negedge clk);
    chk("x0 write read0", if0.rs1_data, 32'h0);
    next_cycle();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 0;
    @(negedge clk);
    chk("x0 after write dut0", if0.rs1_data, 32'h0);
    chk("x0 after write dut1", if1.rs1_data, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk("x0 issue cnt0", 32'(if0.busy_cnt), 32'd0);
    chk("x0 issue cnt1", 32'(if1.busy_cnt), 32'd1);
    write_back(0, 32'h0);

    // RAW stall resolved by same-cycle write-back.
    issue_rd(5);
    next_cycle();
    rs1_addr = 5; rs1_use = 1'b1; iss_valid = 1'b1;
    @(negedge clk);
    chk("raw stall0", 32'(if0.stall), 32'd1);
    chk("raw stall1", 32'(if1.stall), 32'd1);
    next_cycle();
    rs1_addr = 5; rs1_use = 1'b1; iss_valid = 1'b1;
    wb_we = 1'b1; wb_addr = 5; wb_data = 32'h1234;
    @(negedge clk);
    chk("bypass stall0", 32'(if0.stall), 32'd0);
    chk("bypass data0", if0.rs1_data, 32'h1234);
    chk("nobypass stall1", 32'(if1.stall), 32'd1);
    chk("nobypass data1", if1.rs1_data, 32'h0);
    next_cycle();
    rs1_addr = 5;
    @(negedge clk);
    chk("raw done cnt0", 32'(if0.busy_cnt), 32'd0);
    chk("raw done cnt1", 32'(if1.busy_cnt), 32'd0);
    chk("raw done data1", if1.rs1_data, 32'h1234);

    // Same-cycle set and clear of x7: set wins, data lands.
    issue_rd(7);
    wb_we = 1'b1; wb_addr = 7; wb_data = 32'hA5A5A5A5;
    next_cycle();
    rs1_addr = 7;
    @(negedge clk);
    chk("setclr cnt0", 32'(if0.busy_cnt), 32'd1);
    chk("setclr cnt1", 32'(if1.busy_cnt), 32'd1);
    chk("setclr data0", if0.rs1_data, 32'hA5A5A5A5);
    chk("setclr data1", if1.rs1_data, 32'hA5A5A5A5);
    write_back(7, 32'hA5A5A5A5);

    // Read-during-write of x3 while x3 is busy.
    write_back(3, 32'h11);
    issue_rd(3);
    next_cycle();
    rs1_addr = 3; rs1_use = 1'b1; iss_valid = 1'b1;
    wb_we = 1'b1; wb_addr = 3; wb_data = 32'h55;
    @(negedge clk);
    chk("rdw old data1", if1.rs1_data, 32'h11);
    chk("rdw stall1", 32'(if1.stall), 32'd1);
    chk("rdw fwd data0", if0.rs1_data, 32'h55);
    chk("rdw stall0", 32'(if0.stall), 32'd0);
    next_cycle();
    rs1_addr = 3;
    @(negedge clk);
    chk("rdw new data1", if1.rs1_data, 32'h55);
    chk("rdw new data0", if0.rs1_data, 32'h55);

    // Flush beats a concurrent issue.
    issue_rd(1); issue_rd(2); issue_rd(4); issue_rd(6);
    next_cycle();
    @(negedge clk);
    chk("pre-flush cnt0", 32'(if0.busy_cnt), 32'd4);
    chk("pre-flush cnt1", 32'(if1.busy_cnt), 32'd4);
    next_cycle();
    flush = 1'b1; iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 9;
    @(negedge clk);
    chk("flush stall0", 32'(if0.stall), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("flush cnt0", 32'(if0.busy_cnt), 32'd0);
    chk("flush cnt1", 32'(if1.busy_cnt), 32'd0);

    // Fill every register: count saturates at the architectural maximum.
    for (int r = 0; r < NREG; r++) issue_rd(AW'(r));
    next_cycle();
    @(negedge clk);
    chk("full cnt0", 32'(if0.busy_cnt), 32'(NREG - 1));
    chk("full cnt1", 32'(if1.busy_cnt), 32'(NREG));
    next_cycle();
    flush = 1'b1;

    // Asynchronous reset in the middle of a cycle with state populated.
    issue_rd(3);
    next_cycle();
    rs1_addr = 3; rs2_addr = 7; rs1_use = 1'b1; iss_valid = 1'b1;
    #1;
    chk("pre-rst data0", if0.rs1_data, 32'h55);
    chk("pre-rst stall0", 32'(if0.stall), 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst rs1_data0", if0.rs1_data, 32'h0);
    chk("rst rs2_data0", if0.rs2_data, 32'h0);
    chk("rst rs1_data1", if1.rs1_data, 32'h0);
    chk("rst stall0", 32'(if0.stall), 32'd0);
    chk("rst stall1", 32'(if1.stall), 32'd0);
    chk("rst cnt1", 32'(if1.busy_cnt), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rs1_addr  = AW'($urandom_range(NREG - 1, 0));
      rs2_addr  = AW'($urandom_range(NREG - 1, 0));
      rs1_use   = 1'($urandom_range(1, 0));
      rs2_use   = 1'($urandom_range(1, 0));
      iss_valid = ($urandom_range(3, 0) != 0);
      iss_rd_we = ($urandom_range(3, 0) != 0);
      iss_rd    = AW'($urandom_range(NREG - 1, 0));
      wb_we     = ($urandom_range(2, 0) == 0);
      wb_addr   = AW'($urandom_range(NREG - 1, 0));
      wb_data   = $urandom;
      flush     = ($urandom_range(39, 0) == 0);
    end
    next_cycle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with a write-back bypass and a per-register busy scoreboard. It is the successor regfile for the pipelined core. Decode reads two source operands and gets a stall indication when an operand is still in flight. Issue marks the destination as pending, and write-back retires it. Register x0 is optionally hardwired to zero.

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers (power of 2, ≥2).
AW, $clog2(NREG), register address width (derived; do not override).
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = reads return stored value only.
ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy; 0 = register 0 is ordinary.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rs1_addr  in  AW  source 1 address
rs2_addr  in  AW  source 2 address
rs1_use  in  1  instruction in decode reads rs1
rs2_use  in  1  instruction in decode reads rs2
rs1_data  out  XLEN  source 1 operand (combinational)
rs2_data  out  XLEN  source 2 operand (combinational)
iss_valid  in  1  instruction in decode wants to issue this cycle
iss_rd_we  in  1  issuing instruction writes a destination
iss_rd  in  AW  destination address of issuing instruction
stall  out  1  issue blocked this cycle (combinational)
wb_we  in  1  write-back valid
wb_addr  in  AW  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  pipeline flush: clear all busy bits
busy_cnt  out  AW+1  number of registers currently busy (registered)

Behaviour:
Reset and clocking:
- One clock (clk). Reset rst is asynchronous and active-high.
- On rst: all NREG data registers = 0, all busy bits = 0, busy_cnt = 0.
- rst asserted mid-operation discards any in-flight issue or write in that cycle.

Data write:
- Occurs at rising clk when wb_we=1 and NOT (ZERO_REG && wb_addr==0).
- A write to register 0 with ZERO_REG=1 is silently dropped.

Data read (combinational, zero latency):
- Priority: (ZERO_REG && addr==0) → 0.
- Else (BYPASS && wb_we && wb_addr==addr) → wb_data.
- Else → stored value.

Effective busy:
- rsN_busy_eff = busy[rsN_addr] & ~(BYPASS && wb_we && wb_addr==rsN_addr).
- Forced to 0 for address 0 when ZERO_REG=1.

Stall:
- stall = iss_valid & ~flush & ((rs1_use & rs1_busy_eff) | (rs2_use & rs2_busy_eff) | (iss_rd_we & rd_busy_eff)).
- The rd term blocks WAW hazards. rd_busy_eff uses the same bypass rule as the source terms.

Scoreboard update per register r at rising clk, highest priority first:
1. flush=1 → busy[r]=0. The wb data write still happens.
2. set: iss_valid & ~stall & iss_rd_we & iss_rd==r & ~(ZERO_REG && r==0) → busy[r]=1. Set wins over a same-cycle clear on the same r, because the newer producer owns the register.
3. clear: wb_we & wb_addr==r → busy[r]=0.
4. Otherwise busy[r] holds.

Busy count and boundaries:
- busy_cnt = popcount of the busy vector, registered; updated the cycle after a busy change.
- Write-back to a non-busy register is legal: data is written, no scoreboard effect.
- busy_cnt max = NREG (NREG-1 if ZERO_REG=1). It never wraps.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with registers and busy bits populated → rs1_data=rs2_data=0, busy_cnt=0, stall=0 immediately, without waiting for a clock.
- Zero register (ZERO_REG=1): wb_we=1, wb_addr=0, wb_data=0xDEADBEEF → rs1_addr=0 reads 0. Issue to rd=0 → busy_cnt stays 0.
- RAW stall then bypass: issue rd=5 → next cycle rs1_addr=5, rs1_use=1, iss_valid=1 gives stall=1. Then wb_we=1, wb_addr=5, wb_data=0x1234 in the same cycle → stall=0 and rs1_data=0x1234. After the edge, busy_cnt returns to 0.
- Simultaneous set and clear: issue rd=7 and wb_we to 7 in the same cycle → busy[7]=1 after the edge, busy_cnt=1, and the register holds wb_data.
- BYPASS=0 build: write 0x55 to x3 and read x3 in the same cycle → old value returned; next cycle → 0x55. Stall stays asserted during the write-back cycle.
- Flush: set 4 busy registers, assert flush together with an issue to rd=9 → all busy bits clear, issue not recorded, busy_cnt=0 on the following cycle.
